// File: rtl/sm4_serial_ctrl.sv
// Phase sequencer for the bit-serial SM4 state register: load, ROUNDS x 32-cycle
// rounds, a 32-cycle word swap, then unload, one datapath bit per clock.
module sm4_serial_ctrl #(
  parameter int ROUNDS = 32,
  parameter int RND_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             in_ready,
  output logic             key_en,
  output logic [2:0]       ctrl_s,
  output logic             ctrl_rt_s,
  output logic             done,
  output logic [RND_W-1:0] rnd,
  output logic [4:0]       bit_cnt,
  output logic             finish,
  output logic [2:0]       o_dbg_state
);

  // Handshake: start is a level request accepted only in IDLE; in_ready and done
  // each qualify exactly one datapath bit per cycle (MSB first) with no back-pressure,
  // and finish marks the final done cycle, after which the block returns to IDLE.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_INV   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [6:0]       r_cyc;
  logic [6:0]       w_cyc_nx;
  logic [RND_W-1:0] r_rnd;
  logic [RND_W-1:0] w_rnd_nx;
  logic [4:0]       w_bit;

  assign w_bit = r_cyc[4:0];

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cyc   <= 7'd0;
      r_rnd   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cyc   <= w_cyc_nx;
      r_rnd   <= w_rnd_nx;
    end
  end

  // Next-state and counter update
  always_comb begin
    w_state_nx = r_state;
    w_cyc_nx   = r_cyc + 7'd1;
    w_rnd_nx   = r_rnd;
    case (r_state)
      S_IDLE: begin
        w_cyc_nx = 7'd0;
        w_rnd_nx = '0;
        if (start) w_state_nx = S_LOAD;
      end
      S_LOAD: begin
        if (r_cyc == 7'd127) begin
          w_state_nx = S_ROUND;
          w_cyc_nx   = 7'd0;
          w_rnd_nx   = '0;
        end
      end
      S_ROUND: begin
        // Round counter only moves on the last bit of each 32-cycle round.
        if (w_bit == 5'd31) begin
          w_cyc_nx = 7'd0;
          if (r_rnd == LAST_RND) begin
            w_state_nx = S_INV;
            w_rnd_nx   = '0;
          end else begin
            w_rnd_nx = r_rnd + RND_W'(1);
          end
        end
      end
      S_INV: begin
        if (r_cyc == 7'd31) begin
          w_state_nx = S_OUT;
          w_cyc_nx   = 7'd0;
        end
      end
      S_OUT: begin
        if (r_cyc == 7'd127) begin
          w_state_nx = S_IDLE;
          w_cyc_nx   = 7'd0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cyc_nx   = 7'd0;
        w_rnd_nx   = '0;
      end
    endcase
  end

  // Outputs decoded from registered state and counters only
  always_comb begin
    busy      = 1'b1;
    in_ready  = 1'b0;
    key_en    = 1'b0;
    ctrl_s    = 3'd4;
    ctrl_rt_s = 1'b0;
    done      = 1'b0;
    rnd       = '0;
    bit_cnt   = w_bit;
    finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy    = 1'b0;
        bit_cnt = 5'd0;
      end
      S_LOAD: begin
        ctrl_s   = 3'd0;
        in_ready = 1'b1;
      end
      S_ROUND: begin
        key_en    = 1'b1;
        rnd       = r_rnd;
        ctrl_rt_s = (w_bit >= 5'd8);
        if (w_bit < 5'd2)       ctrl_s = 3'd1;
        else if (w_bit < 5'd10) ctrl_s = 3'd3;
        else if (w_bit < 5'd18) ctrl_s = 3'd2;
        else if (w_bit < 5'd24) ctrl_s = 3'd6;
        else                    ctrl_s = 3'd7;
      end
      S_INV: begin
        ctrl_s = 3'd5;
      end
      S_OUT: begin
        done   = 1'b1;
        finish = (r_cyc == 7'd127);
      end
      default: begin
        busy    = 1'b0;
        bit_cnt = 5'd0;
      end
    endcase
  end

  assign o_dbg_state = r_state;

  a_code0_only_load: assert property (@(posedge clk) disable iff (rst)
    (ctrl_s == 3'd0) |-> (r_state == S_LOAD));
  a_finish_in_out: assert property (@(posedge clk) disable iff (rst)
    finish |-> done);
  a_phase_exclusive: assert property (@(posedge clk) disable iff (rst)
    $onehot0({in_ready, key_en, done}));

endmodule

// File: tb/tb_sm4_serial_ctrl.sv
// Directed bench for sm4_serial_ctrl: reset values, full-block phase timing,
// reset abort, held start, and a single-round configuration.
module tb_sm4_serial_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start1;

  logic       busy, in_ready, key_en, ctrl_rt_s, done, finish;
  logic [2:0] ctrl_s, dbg_state;
  logic [4:0] rnd, bit_cnt;

  logic       busy_1, in_ready_1, key_en_1, ctrl_rt_s_1, done_1, finish_1;
  logic [2:0] ctrl_s_1, dbg_state_1;
  logic [4:0] rnd_1, bit_cnt_1;

  int n_checks = 0;
  int n_errors = 0;

  // {busy,in_ready,key_en,ctrl_s,ctrl_rt_s,done,rnd,bit_cnt,finish}
  logic [18:0] obs, obs1;
  assign obs  = {busy, in_ready, key_en, ctrl_s, ctrl_rt_s, done, rnd, bit_cnt, finish};
  assign obs1 = {busy_1, in_ready_1, key_en_1, ctrl_s_1, ctrl_rt_s_1, done_1, rnd_1,
                 bit_cnt_1, finish_1};

  localparam logic [18:0] IDLE_VEC = {1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0};

  sm4_serial_ctrl #(.ROUNDS(32), .RND_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .in_ready(in_ready),
    .key_en(key_en), .ctrl_s(ctrl_s), .ctrl_rt_s(ctrl_rt_s), .done(done),
    .rnd(rnd), .bit_cnt(bit_cnt), .finish(finish), .o_dbg_state(dbg_state)
  );

  sm4_serial_ctrl #(.ROUNDS(1), .RND_W(5)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy_1), .in_ready(in_ready_1),
    .key_en(key_en_1), .ctrl_s(ctrl_s_1), .ctrl_rt_s(ctrl_rt_s_1), .done(done_1),
    .rnd(rnd_1), .bit_cnt(bit_cnt_1), .finish(finish_1), .o_dbg_state(dbg_state_1)
  );

  // Expected outputs r cycles after the edge that sampled start (r=1: first LOAD cycle).
  function automatic logic [18:0] exp_vec(input int r, input int rounds);
    int unsigned rs_tab [32] = '{1, 1, 3, 3, 3, 3, 3, 3, 3, 3, 2, 2, 2, 2, 2, 2,
                                 2, 2, 6, 6, 6, 6, 6, 6, 7, 7, 7, 7, 7, 7, 7, 7};
    logic [2:0] cs;
    logic       b, ir, ke, rt, dn, fn;
    logic [4:0] rn, bc;
    int         rs, is, os, total, k;
    b = 1'b0; ir = 1'b0; ke = 1'b0; rt = 1'b0; dn = 1'b0; fn = 1'b0;
    cs = 3'd4; rn = 5'd0; bc = 5'd0;
    rs    = 129;
    is    = rs + 32 * rounds;
    os    = is + 32;
    total = os + 127;
    if (r >= 1 && r <= 128) begin
      b = 1'b1; ir = 1'b1; cs = 3'd0; bc = 5'((r - 1) % 32);
    end else if (r >= rs && r < is) begin
      k  = r - rs;
      b  = 1'b1; ke = 1'b1;
      rn = 5'(k / 32);
      bc = 5'(k % 32);
      cs = 3'(rs_tab[k % 32]);
      rt = ((k % 32) >= 8);
    end else if (r >= is && r < os) begin
      b = 1'b1; cs = 3'd5; bc = 5'(r - is);
    end else if (r >= os && r <= total) begin
      b = 1'b1; dn = 1'b1; bc = 5'((r - os) % 32); fn = (r == total);
    end
    return {b, ir, ke, cs, rt, dn, rn, bc, fn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (obs !== IDLE_VEC) begin
        n_errors++;
        $display("FAIL reset_idle cyc=%0d: got %b expected %b", i, obs, IDLE_VEC);
      end
      n_checks++;
      if (obs1 !== IDLE_VEC || dbg_state !== 3'd0) begin
        n_errors++;
        $display("FAIL reset_idle_r1 cyc=%0d: got %b st=%0d expected %b st=0",
                 i, obs1, dbg_state, IDLE_VEC);
      end
      tick();
    end
  endtask

  task automatic test_full_block();
    int busy_cnt;
    logic [18:0] e;
    busy_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r <= 1313; r++) begin
      e = exp_vec(r, 32);
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL full_block r=%0d: got %b expected %b", r, obs, e);
      end
      if (busy) busy_cnt++;
      tick();
    end
    n_checks++;
    if (busy_cnt != 1312) begin
      n_errors++;
      $display("FAIL busy_length: got %0d expected 1312", busy_cnt);
    end
  endtask

  task automatic test_reset_mid_load();
    int ir_cnt;
    logic [18:0] e;
    ir_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r <= 50; r++) tick();
    n_checks++;
    if (in_ready !== 1'b1 || bit_cnt !== 5'd18) begin
      n_errors++;
      $display("FAIL load_cyc50: got in_ready=%b bit_cnt=%0d expected 1/18", in_ready, bit_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs !== IDLE_VEC || dbg_state !== 3'd0) begin
        n_errors++;
        $display("FAIL abort_idle i=%0d: got %b st=%0d expected %b st=0",
                 i, obs, dbg_state, IDLE_VEC);
      end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r <= 1313; r++) begin
      e = exp_vec(r, 32);
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL after_abort r=%0d: got %b expected %b", r, obs, e);
      end
      if (in_ready) ir_cnt++;
      tick();
    end
    n_checks++;
    if (ir_cnt != 128) begin
      n_errors++;
      $display("FAIL load_length: got %0d expected 128", ir_cnt);
    end
  endtask

  task automatic test_start_held();
    logic [18:0] e;
    start = 1'b1;
    tick();
    for (int r = 1; r <= 1312; r++) begin
      e = exp_vec(r, 32);
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL held_blk1 r=%0d: got %b expected %b", r, obs, e);
      end
      tick();
    end
    n_checks++;
    if (obs !== IDLE_VEC) begin
      n_errors++;
      $display("FAIL held_gap: got %b expected %b", obs, IDLE_VEC);
    end
    tick();
    // Second block: start toggles randomly while busy, then drops before the end.
    for (int r = 1; r <= 1314; r++) begin
      e = exp_vec(r, 32);
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL held_blk2 r=%0d: got %b expected %b", r, obs, e);
      end
      start = (r < 1290) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
  endtask

  task automatic test_rounds1();
    int k_cnt, fin_at;
    logic [18:0] e;
    k_cnt = 0; fin_at = -1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int r = 1; r <= 321; r++) begin
      e = exp_vec(r, 1);
      n_checks++;
      if (obs1 !== e) begin
        n_errors++;
        $display("FAIL rounds1 r=%0d: got %b expected %b", r, obs1, e);
      end
      if (key_en_1) k_cnt++;
      if (finish_1) fin_at = r;
      tick();
    end
    n_checks++;
    if (k_cnt != 32 || fin_at != 320) begin
      n_errors++;
      $display("FAIL rounds1_timing: got key_en=%0d finish_at=%0d expected 32/320", k_cnt, fin_at);
    end
    n_checks++;
    if (dbg_state_1 !== 3'd0) begin
      n_errors++;
      $display("FAIL rounds1_end_state: got %0d expected 0", dbg_state_1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    test_reset();
    test_full_block();
    test_reset_mid_load();
    test_start_held();
    test_rounds1();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sm4_serial_ctrl.md
Name: sm4_serial_ctrl

Overview:
- Sequencer for the bit-serial SM4 state register (4x32-bit shift datapath, one bit per clock).
- Drives the datapath phase code, the round-transform select and the output enable.
- Sequences load (128 bits in), ROUNDS x 32-cycle rounds, a 32-cycle word-swap, and unload (128 bits out).
- Provides a start/busy/finish handshake to the host and round/bit indices plus a key shift enable to the key-schedule block.

Parameters:
- ROUNDS, 32, number of cipher rounds executed; legal 1..32.
- RND_W, 5, width of round index output; must satisfy 2^RND_W >= ROUNDS.

Ports:
- clk      in   1      rising-edge clock.
- rst      in   1      synchronous, active-high reset.
- start    in   1      begin a block; sampled only in IDLE.
- busy     out  1      high in every state except IDLE.
- in_ready out  1      high during LOAD; host presents plaintext bit on the datapath `in` that cycle, MSB first.
- key_en   out  1      high during ROUND; key schedule shifts one round-key bit (rk) per cycle.
- ctrl_s   out  3      datapath phase code (see Behaviour).
- ctrl_rt_s out 1      datapath round-transform feedback select.
- done     out  1      datapath output enable; high during OUT; out_c valid, MSB first.
- rnd      out  RND_W  current round index, 0..ROUNDS-1; 0 outside ROUND.
- bit_cnt  out  5      bit index within current 32-cycle word/round; 0 in IDLE.
- finish   out  1      one-cycle pulse on the last OUT cycle.

Behaviour:
- States: IDLE, LOAD, ROUND, INV, OUT.
  - Counters: cyc (7 bit), rnd (RND_W), bit_cnt = cyc[4:0].
  - All outputs are decoded from registered state/counters only; there is no combinational input-to-output path.
- Reset (sync, rst=1 at a clock edge): state=IDLE, counters=0.
  - Outputs after reset: busy=0, in_ready=0, key_en=0, ctrl_s=4, ctrl_rt_s=0, done=0, rnd=0, bit_cnt=0, finish=0.
  - Reset mid-operation aborts immediately; the next cycle is IDLE with the values above. Datapath contents are don't-care.
- IDLE:
  - ctrl_s=4, so the datapath rotates and preserves its contents.
  - start=1 -> LOAD next cycle with cyc=0.
- LOAD:
  - 128 cycles, cyc 0..127, ctrl_s=0, in_ready=1, ctrl_rt_s=0.
  - At cyc=127 -> ROUND with cyc=0, rnd=0.
- ROUND:
  - ctrl_s decoded from bit_cnt: 0-1 -> 1; 2-9 -> 3; 10-17 -> 2; 18-23 -> 6; 24-31 -> 7.
  - ctrl_rt_s=1 for bit_cnt 8..31, else 0.
  - key_en=1.
  - bit_cnt=31 with rnd<ROUNDS-1: rnd increments, bit_cnt wraps to 0.
  - bit_cnt=31 with rnd=ROUNDS-1 -> INV, cyc=0.
- INV:
  - 32 cycles, ctrl_s=5, ctrl_rt_s=0, key_en=0; swaps words 0/2, words 1/3 hold.
  - At cyc=31 -> OUT, cyc=0.
- OUT:
  - 128 cycles, ctrl_s=4, done=1.
  - finish=1 only at cyc=127; the next state is IDLE.
- start:
  - Ignored in every state except IDLE.
  - start held high across finish begins a new block on the cycle after return to IDLE; there is no back-to-back start from OUT.
- Latency:
  - start sampled at edge T: first in_ready in cycle T+1.
  - finish at cycle T+1+128+32*ROUNDS+32+127.
  - ROUNDS=32: finish at T+1312; busy high for exactly 1312 cycles.
- ctrl_s never takes a value outside {0,1,2,3,4,5,6,7 as listed}.
  - Code 0 is only ever driven in LOAD.

Test Plan:
- Reset then idle 10 cycles -> all outputs at reset values, ctrl_s=4 constant.
- start pulse at cycle 5 (ROUNDS=32):
  - in_ready high cycles 6..133.
  - key_en high cycles 134..1157.
  - ctrl_s=5 cycles 1158..1189.
  - done high cycles 1190..1317.
  - finish only at 1317.
- ROUND decode check, round 7:
  - ctrl_s sequence per bit_cnt 0..31 = 1,1,3x8,2x8,6x6,7x8.
  - ctrl_rt_s rises at bit_cnt=8; rnd=7 throughout.
- Reset asserted at LOAD cyc=50 -> next cycle IDLE, busy=0, in_ready=0; a following start gives a full 128-cycle LOAD.
- start held high continuously:
  - Blocks repeat.
  - After finish, one IDLE cycle (busy=0), then in_ready high again.
  - start pulses during ROUND have no effect.
- ROUNDS=1: key_en high exactly 32 cycles, rnd stays 0, finish at T+1+128+32+32+127.
- End-to-end with datapath and key schedule: standard SM4 vector.
  - Plaintext 0123456789abcdeffedcba9876543210, same key.
  - Serial out_c during done = 681edf34d206965e86b3e94f536e4246.
